// File: rtl/sgd_dot_accum.sv
// SGD dot-product accumulator: sums adder-tree beats per sample, subtracts a FIFO label, scales the error.
// Optional saturation of the accumulate/subtract datapath is enabled by defining SGD_DOT_SAT_EN.
module sgd_dot_accum #(
    parameter int LABEL_FIFO_DEPTH = 16,
    parameter int SHIFT_WIDTH      = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            num_chunks,
    input  logic [31:0]            num_samples,
    input  logic [SHIFT_WIDTH-1:0] step_shift,
    input  logic signed [31:0]     v_input,
    input  logic                   v_input_valid,
    input  logic signed [31:0]     label,
    input  logic                   label_valid,
    output logic                   label_ready,
    output logic signed [31:0]     grad_out,
    output logic                   grad_valid,
    output logic                   done,
    output logic                   label_underflow,
    output logic                   busy
);

    localparam int AW = $clog2(LABEL_FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(LABEL_FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]             state;
    logic [15:0]            chunks_r;
    logic [31:0]            samples_r;
    logic [SHIFT_WIDTH-1:0] shift_r;
    logic [15:0]            chunk_cnt;
    logic signed [31:0]     acc;
    logic [31:0]            sample_cnt;
    logic signed [31:0]     dot_r;
    logic signed [31:0]     label_r;
    logic                   s1_valid;

    logic [31:0]            mem [LABEL_FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic                   fifo_empty;
    logic                   push;
    logic                   last_beat;

    // Add or subtract; the saturating build clamps using a 33-bit intermediate.
    function automatic logic signed [31:0] add_op(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input logic sub);
`ifdef SGD_DOT_SAT_EN
        logic signed [32:0] s;
        s = sub ? ({a[31], a} - {b[31], b}) : ({a[31], a} + {b[31], b});
        if (s[32] != s[31])
            return s[32] ? 32'sh80000000 : 32'sh7FFFFFFF;
        return $signed(s[31:0]);
`else
        return sub ? (a - b) : (a + b);
`endif
    endfunction

    assign busy        = (state == ST_RUN);
    assign fifo_empty  = (count == '0);
    assign label_ready = !rst && (count != FULL_CNT);
    assign push        = label_valid && label_ready;
    assign last_beat   = (state == ST_RUN) && v_input_valid && !start &&
                         (chunk_cnt == chunks_r - 16'd1);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= label;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (last_beat && !fifo_empty)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, last_beat && !fifo_empty})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Accumulate beats, then two pipeline stages: dot/label capture, then scaled error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            chunks_r        <= 16'd1;
            samples_r       <= '0;
            shift_r         <= '0;
            chunk_cnt       <= '0;
            acc             <= '0;
            sample_cnt      <= '0;
            dot_r           <= '0;
            label_r         <= '0;
            s1_valid        <= 1'b0;
            grad_out        <= '0;
            grad_valid      <= 1'b0;
            done            <= 1'b0;
            label_underflow <= 1'b0;
        end else begin
            grad_valid <= 1'b0;
            done       <= 1'b0;
            s1_valid   <= last_beat;

            if (last_beat) begin
                dot_r   <= add_op(acc, v_input, 1'b0);
                label_r <= fifo_empty ? 32'sd0 : $signed(mem[rd_ptr]);
            end

            if (s1_valid) begin
                grad_out   <= add_op(dot_r, label_r, 1'b1) >>> shift_r;
                grad_valid <= 1'b1;
                sample_cnt <= sample_cnt + 32'd1;
                if (state == ST_RUN && samples_r != 32'd0 &&
                    sample_cnt + 32'd1 == samples_r) begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
            end

            if (start) begin
                state           <= ST_RUN;
                chunks_r        <= (num_chunks == 16'd0) ? 16'd1 : num_chunks;
                samples_r       <= num_samples;
                shift_r         <= step_shift;
                chunk_cnt       <= '0;
                acc             <= '0;
                sample_cnt      <= '0;
                done            <= 1'b0;
                label_underflow <= 1'b0;
            end else if (state == ST_RUN && v_input_valid) begin
                if (last_beat) begin
                    chunk_cnt <= '0;
                    acc       <= '0;
                end else begin
                    chunk_cnt <= chunk_cnt + 16'd1;
                    acc       <= add_op(acc, v_input, 1'b0);
                end
            end

            if (last_beat && fifo_empty)
                label_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sgd_dot_accum.sv
// Directed bench for sgd_dot_accum; expected values follow SGD_DOT_SAT_EN when defined.
module tb_sgd_dot_accum;

    logic               clk;
    logic               rst;
    logic               start;
    logic [15:0]        num_chunks;
    logic [31:0]        num_samples;
    logic [4:0]         step_shift;
    logic signed [31:0] v_input;
    logic               v_input_valid;
    logic signed [31:0] label;
    logic               label_valid;
    logic               label_ready;
    logic signed [31:0] grad_out;
    logic               grad_valid;
    logic               done;
    logic               label_underflow;
    logic               busy;

    int check_cnt = 0;
    int pass_cnt  = 0;

    typedef struct packed {
        logic [15:0]      chunks;
        logic [4:0]       shift;
        logic [3:0][31:0] beats;
        logic [2:0]       nb;
        logic [31:0]      lbl;
        logic [31:0]      exp_grad;
    } vec_t;

    vec_t vecs [9];

    sgd_dot_accum #(.LABEL_FIFO_DEPTH(16), .SHIFT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks),
        .num_samples(num_samples), .step_shift(step_shift), .v_input(v_input),
        .v_input_valid(v_input_valid), .label(label), .label_valid(label_valid),
        .label_ready(label_ready), .grad_out(grad_out), .grad_valid(grad_valid),
        .done(done), .label_underflow(label_underflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        check_cnt++;
        if (act === expv)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    endtask

    task automatic set_vec(input int idx, input logic [15:0] ch, input logic [4:0] sh,
                           input logic [2:0] nb, input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3,
                           input logic [31:0] lbl, input logic [31:0] expg);
        vecs[idx].chunks   = ch;
        vecs[idx].shift    = sh;
        vecs[idx].nb       = nb;
        vecs[idx].beats[0] = b0;
        vecs[idx].beats[1] = b1;
        vecs[idx].beats[2] = b2;
        vecs[idx].beats[3] = b3;
        vecs[idx].lbl      = lbl;
        vecs[idx].exp_grad = expg;
    endtask

    task automatic push_label(input logic [31:0] val);
        label       = val;
        label_valid = 1'b1;
        tick();
        label_valid = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] ch, input logic [31:0] ns, input logic [4:0] sh);
        num_chunks  = ch;
        num_samples = ns;
        step_shift  = sh;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic beat(input logic [31:0] val);
        v_input       = val;
        v_input_valid = 1'b1;
        tick();
        v_input_valid = 1'b0;
        v_input       = '0;
    endtask

    // Called right after the last beat's edge; returns the cycle index (beat cycle = 0) of grad_valid.
    task automatic wait_grad(output int n);
        n = 1;
        do begin
            tick();
            n++;
        end while (!grad_valid && n < 12);
    endtask

    task automatic applyStimulus(input vec_t v, output int lat);
        push_label(v.lbl);
        start_run(v.chunks, 32'd1, v.shift);
        for (int i = 0; i < int'(v.nb); i++)
            beat(v.beats[i]);
        wait_grad(lat);
    endtask

    initial begin
        int lat;
        logic       gv [8];
        logic       dn [8];
        logic [31:0] go [8];
        logic       seen;

        set_vec(0, 16'd3, 5'd0, 3'd3, 32'd10, 32'd20, 32'd30, 32'd0, 32'd50, 32'd10);
        set_vec(1, 16'd2, 5'd2, 3'd2, -32'sd100, -32'sd4, 32'd0, 32'd0, 32'd0, -32'sd26);
        set_vec(2, 16'd1, 5'd0, 3'd1, 32'd5, 32'd0, 32'd0, 32'd0, 32'd8, -32'sd3);
        set_vec(3, 16'd0, 5'd1, 3'd1, 32'd9, 32'd0, 32'd0, 32'd0, 32'd2, 32'd3);
        set_vec(4, 16'd4, 5'd3, 3'd4, 32'd1, 32'd2, 32'd3, 32'd4, -32'sd30, 32'd5);
        set_vec(5, 16'd1, 5'd4, 3'd1, -32'sd17, 32'd0, 32'd0, 32'd0, 32'd0, -32'sd2);
`ifdef SGD_DOT_SAT_EN
        set_vec(6, 16'd2, 5'd0, 3'd2, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'h7FFFFFFF);
        set_vec(7, 16'd2, 5'd0, 3'd2, 32'h80000000, -32'sd1, 32'd0, 32'd0, 32'd0, 32'h80000000);
        set_vec(8, 16'd1, 5'd0, 3'd1, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'd1, 32'h80000000);
`else
        set_vec(6, 16'd2, 5'd0, 3'd2, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'h80000000);
        set_vec(7, 16'd2, 5'd0, 3'd2, 32'h80000000, -32'sd1, 32'd0, 32'd0, 32'd0, 32'h7FFFFFFF);
        set_vec(8, 16'd1, 5'd0, 3'd1, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'd1, 32'h7FFFFFFF);
`endif

        rst = 1'b1; start = 1'b0; num_chunks = '0; num_samples = '0; step_shift = '0;
        v_input = '0; v_input_valid = 1'b0; label = '0; label_valid = 1'b0;
        tick();
        tick();
        checkOutput("rst_label_ready", 32'(label_ready), 32'd0);
        checkOutput("rst_grad_valid", 32'(grad_valid), 32'd0);
        checkOutput("rst_grad_out", grad_out, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_underflow", 32'(label_underflow), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_label_ready", 32'(label_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], lat);
            checkOutput($sformatf("vec%0d_grad", i), grad_out, vecs[i].exp_grad);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            checkOutput($sformatf("vec%0d_done", i), 32'(done), 32'd1);
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            checkOutput($sformatf("vec%0d_underflow", i), 32'(label_underflow), 32'd0);
            tick();
            checkOutput($sformatf("vec%0d_hold_valid", i), 32'(grad_valid), 32'd0);
            checkOutput($sformatf("vec%0d_hold_grad", i), grad_out, vecs[i].exp_grad);
        end

        // Back-to-back single-beat samples, done with the fourth.
        for (int i = 0; i < 4; i++)
            push_label(32'd0);
        start_run(16'd1, 32'd4, 5'd0);
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                v_input = 32'(k + 1);
                v_input_valid = 1'b1;
            end else begin
                v_input_valid = 1'b0;
            end
            tick();
            gv[k] = grad_valid;
            go[k] = grad_out;
            dn[k] = done;
        end
        v_input_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("b2b_valid%0d", k), 32'(gv[k]), (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("b2b_done%0d", k), 32'(dn[k]), (k == 4) ? 32'd1 : 32'd0);
            if (k >= 1 && k <= 4)
                checkOutput($sformatf("b2b_grad%0d", k), go[k], 32'(k));
        end
        checkOutput("b2b_busy", 32'(busy), 32'd0);

        // Sample with empty label FIFO.
        start_run(16'd1, 32'd1, 5'd0);
        beat(32'd7);
        wait_grad(lat);
        checkOutput("uflow_grad", grad_out, 32'd7);
        checkOutput("uflow_flag", 32'(label_underflow), 32'd1);
        tick();
        tick();
        checkOutput("uflow_sticky", 32'(label_underflow), 32'd1);

        // Restart mid-sample discards the partial sum and clears the flag.
        push_label(32'd1);
        start_run(16'd3, 32'd1, 5'd0);
        checkOutput("restart_uflow_clr", 32'(label_underflow), 32'd0);
        beat(32'd5);
        beat(32'd5);
        start_run(16'd2, 32'd1, 5'd0);
        beat(32'd3);
        beat(32'd4);
        wait_grad(lat);
        checkOutput("restart_grad", grad_out, 32'd6);
        checkOutput("restart_latency", 32'(lat), 32'd2);

        // Fill the label FIFO, then free one slot with a sample.
        start_run(16'd1, 32'd1, 5'd0);
        for (int i = 0; i < 16; i++) begin
            label       = 32'(100 + i);
            label_valid = 1'b1;
            tick();
            if (i == 14)
                checkOutput("fifo_ready_15", 32'(label_ready), 32'd1);
        end
        label_valid = 1'b0;
        checkOutput("fifo_full_ready", 32'(label_ready), 32'd0);
        beat(32'd5);
        checkOutput("fifo_pop_ready", 32'(label_ready), 32'd1);
        wait_grad(lat);
        checkOutput("fifo_grad", grad_out, -32'sd95);

        // Reset in the middle of accumulation.
        start_run(16'd3, 32'd0, 5'd0);
        beat(32'd1);
        beat(32'd2);
        rst = 1'b1;
        tick();
        checkOutput("midrst_label_ready", 32'(label_ready), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | grad_valid;
        end
        checkOutput("midrst_no_grad", 32'(seen), 32'd0);

        // Reset while a completed sample is in flight.
        start_run(16'd1, 32'd0, 5'd0);
        beat(32'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | grad_valid;
        end
        checkOutput("inflight_rst_no_grad", 32'(seen), 32'd0);

        // Accumulator starts clean after reset.
        push_label(32'd0);
        start_run(16'd3, 32'd1, 5'd0);
        beat(32'd1);
        beat(32'd2);
        beat(32'd3);
        wait_grad(lat);
        checkOutput("post_rst_grad", grad_out, 32'd6);
        checkOutput("post_rst_done", 32'(done), 32'd1);

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
